// File: rtl/dense_layer_mac.sv
// dense_layer_mac: fixed-point dense (fully connected) layer. Each vector takes one signed
// 32x32 multiply-accumulate per cycle, walking the weight matrix row-major. Each row starts
// from its bias scaled up by FRAC_BITS. The accumulated sum is then shifted back down
// arithmetically and narrowed to 32 bits.
//
// Optional feature: define DENSE_LAYER_MAC_SATURATE_EN to clamp the narrowed result to the
// signed 32-bit range. When it is undefined, the result keeps the low 32 bits and wraps.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data parameter write; addr = row*(IN_LEN+1)+col, col=IN_LEN is the bias
//   in_valid/in_ready    input vector handshake; in_data packs x[c] at bits [c*32 +: 32]
//   out_valid/out_ready  result handshake; out_data packs out[r] at bits [r*32 +: 32]
module dense_layer_mac #(
  parameter int unsigned IN_LEN    = 3,
  parameter int unsigned OUT_LEN   = 3,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    wr_en,
  input  logic [$clog2(OUT_LEN*(IN_LEN+1))-1:0]   wr_addr,
  input  logic [31:0]                             wr_data,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [32*IN_LEN-1:0]                    in_data,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [32*OUT_LEN-1:0]                   out_data
);

  localparam int unsigned NParam = OUT_LEN * (IN_LEN + 1);
  localparam int unsigned AW     = $clog2(NParam);
  localparam int unsigned CW     = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int unsigned RW     = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam logic [CW-1:0] ColLast = CW'(IN_LEN - 1);
  localparam logic [RW-1:0] RowLast = RW'(OUT_LEN - 1);

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e             state_q, state_d;
  logic signed [31:0] mem_q [NParam];
  logic signed [31:0] x_q [IN_LEN];
  logic        [31:0] out_q [OUT_LEN];
  logic [CW-1:0]      col_q;
  logic [RW-1:0]      row_q;
  logic signed [63:0] acc_q;

  logic               wr_ok;
  logic signed [31:0] bias0;
  logic [AW-1:0]      w_idx;
  logic [AW-1:0]      nb_idx;
  logic signed [31:0] w_cur;
  logic signed [31:0] x_cur;
  logic signed [63:0] prod;
  logic signed [63:0] acc_sum;
  logic        [31:0] conv;
  logic               last_col;
  logic               last_row;

  // Bias in accumulator scale: sign-extend to 64 bits, then align with the products.
  function automatic logic signed [63:0] bias_ext(input logic signed [31:0] b);
    return $signed({{32{b[31]}}, b}) <<< FRAC_BITS;
  endfunction

  always_comb begin
    wr_ok    = wr_en && (state_q == StIdle) && (32'(wr_addr) < NParam);
    // A bias-0 write on the accepting edge must already be seen by the accumulator load.
    bias0    = (wr_ok && (wr_addr == AW'(IN_LEN))) ? wr_data : mem_q[AW'(IN_LEN)];
    last_col = (col_q == ColLast);
    last_row = (row_q == RowLast);
    w_idx    = AW'(32'(row_q) * (IN_LEN + 1) + 32'(col_q));
    // On the last row the reload value is unused; point at a valid entry anyway.
    nb_idx   = last_row ? AW'(IN_LEN) : AW'((32'(row_q) + 1) * (IN_LEN + 1) + IN_LEN);
    w_cur    = mem_q[w_idx];
    x_cur    = x_q[col_q];
    prod     = $signed({{32{w_cur[31]}}, w_cur}) * $signed({{32{x_cur[31]}}, x_cur});
    acc_sum  = acc_q + prod;
  end

`ifdef DENSE_LAYER_MAC_SATURATE_EN
  logic signed [63:0] shifted;
  always_comb begin
    shifted = acc_sum >>> FRAC_BITS;
    // Bits 63..31 all equal means the value fits in signed 32 bits.
    if (!(&shifted[63:31]) && (|shifted[63:31])) begin
      conv = shifted[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      conv = shifted[31:0];
    end
  end
`else
  always_comb begin
    conv = 32'(acc_sum >>> FRAC_BITS);
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_valid) state_d = StCompute;
      StCompute: if (last_col && last_row) state_d = StDone;
      StDone:    if (out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_data  = '0;
    for (int r = 0; r < int'(OUT_LEN); r++) begin
      out_data[r*32 +: 32] = out_q[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      for (int i = 0; i < int'(NParam); i++) mem_q[i] <= '0;
      for (int c = 0; c < int'(IN_LEN); c++) x_q[c] <= '0;
      for (int r = 0; r < int'(OUT_LEN); r++) out_q[r] <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (wr_ok) mem_q[wr_addr] <= wr_data;
          if (in_valid) begin
            for (int c = 0; c < int'(IN_LEN); c++) x_q[c] <= in_data[c*32 +: 32];
            row_q <= '0;
            col_q <= '0;
            acc_q <= bias_ext(bias0);
          end
        end
        StCompute: begin
          if (last_col) begin
            out_q[row_q] <= conv;
            acc_q        <= bias_ext(mem_q[nb_idx]);
            col_q        <= '0;
            row_q        <= last_row ? '0 : row_q + 1'b1;
          end else begin
            acc_q <= acc_sum;
            col_q <= col_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_mac.sv
module tb_dense_layer_mac;

  localparam int IN_LEN  = 3;
  localparam int OUT_LEN = 3;
  localparam int FRAC    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [95:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [95:0] out_data;

  int total = 0;
  int bad   = 0;

  // Reference state: what the parameter memory should hold, and the current input vector.
  int tb_w [3][3];
  int tb_b [3];
  int cur_x [3];

  dense_layer_mac #(
    .IN_LEN   (IN_LEN),
    .OUT_LEN  (OUT_LEN),
    .FRAC_BITS(FRAC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // out[r] = (b<<F + sum w*x) >>> F in 64-bit wrapping arithmetic, then narrowed.
  function automatic logic [31:0] model_out(input int r);
    longint acc;
    longint sh;
    acc = longint'(tb_b[r]) <<< FRAC;
    for (int c = 0; c < IN_LEN; c++) acc += longint'(tb_w[r][c]) * longint'(cur_x[c]);
    sh = acc >>> FRAC;
`ifdef DENSE_LAYER_MAC_SATURATE_EN
    if (sh > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (sh < -(64'sd2147483648)) return 32'h8000_0000;
`endif
    return sh[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic load_model();
    for (int r = 0; r < OUT_LEN; r++) begin
      for (int c = 0; c < IN_LEN; c++) wr(r * 4 + c, tb_w[r][c]);
      wr(r * 4 + 3, tb_b[r]);
    end
  endtask

  task automatic clear_model();
    for (int r = 0; r < OUT_LEN; r++) begin
      tb_b[r] = 0;
      for (int c = 0; c < IN_LEN; c++) tb_w[r][c] = 0;
    end
  endtask

  task automatic drive_x();
    for (int c = 0; c < IN_LEN; c++) in_data[c*32 +: 32] = cur_x[c];
  endtask

  task automatic accept();
    drive_x();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 96'd0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    #1 rst_n = 1'b1;
    step();
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
    clear_model();
  endtask

  task automatic test_identity();
    int n;
    logic [31:0] want [3];
    clear_model();
    for (int r = 0; r < OUT_LEN; r++) tb_w[r][r] = 32'h0001_0000;
    load_model();
    cur_x[0] = 32'h0001_0000; cur_x[1] = 32'h0002_0000; cur_x[2] = 32'hFFFF_0000;
    want[0] = 32'h0001_0000; want[1] = 32'h0002_0000; want[2] = 32'hFFFF_0000;
    accept();
    wait_done(n);
    total++; if (n != 9) begin bad++; $display("FAIL identity_latency got=%0d want=9", n); end
    for (int r = 0; r < OUT_LEN; r++) begin
      total++;
      if (out_data[r*32 +: 32] !== want[r]) begin
        bad++; $display("FAIL identity_out%0d got=%h want=%h", r, out_data[r*32 +: 32], want[r]);
      end
    end
    release_out();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL identity_back_idle got=%b want=1", in_ready); end
  endtask

  task automatic test_bias_negative();
    int n;
    logic [31:0] want [3];
    for (int r = 0; r < OUT_LEN; r++)
      for (int c = 0; c < IN_LEN; c++) tb_w[r][c] = 32'h0000_8000;
    tb_b[0] = 32'h0001_0000; tb_b[1] = 0; tb_b[2] = 32'hFFFE_0000;
    load_model();
    cur_x[0] = 32'h0002_0000; cur_x[1] = 32'h0002_0000; cur_x[2] = 32'hFFFE_0000;
    want[0] = 32'h0002_0000; want[1] = 32'h0001_0000; want[2] = 32'hFFFF_0000;
    accept();
    wait_done(n);
    for (int r = 0; r < OUT_LEN; r++) begin
      total++;
      if (out_data[r*32 +: 32] !== want[r]) begin
        bad++; $display("FAIL bias_neg_out%0d got=%h want=%h", r, out_data[r*32 +: 32], want[r]);
      end
    end
    release_out();
  endtask

  task automatic test_overflow();
    int n;
    logic [31:0] want0;
    clear_model();
    tb_w[0][0] = 32'h7FFF_0000;
    load_model();
    cur_x[0] = 32'h7FFF_0000; cur_x[1] = 32'h1234_5678; cur_x[2] = 32'h8765_4321;
`ifdef DENSE_LAYER_MAC_SATURATE_EN
    want0 = 32'h7FFF_FFFF;
`else
    want0 = 32'h0001_0000;
`endif
    accept();
    wait_done(n);
    total++; if (out_data[31:0] !== want0) begin bad++; $display("FAIL overflow_out0 got=%h want=%h", out_data[31:0], want0); end
    total++; if (out_data[95:32] !== 64'd0) begin bad++; $display("FAIL overflow_rest got=%h want=0", out_data[95:32]); end
    release_out();
  endtask

  task automatic test_backpressure();
    int n;
    logic [95:0] snap;
    logic [95:0] want;
    for (int r = 0; r < OUT_LEN; r++) begin
      tb_b[r] = $urandom_range(0, 32'h3_FFFF) - 32'h2_0000;
      for (int c = 0; c < IN_LEN; c++) tb_w[r][c] = $urandom_range(0, 32'h3_FFFF) - 32'h2_0000;
    end
    load_model();
    for (int c = 0; c < IN_LEN; c++) cur_x[c] = $urandom_range(0, 32'h7_FFFF) - 32'h4_0000;
    for (int r = 0; r < OUT_LEN; r++) want[r*32 +: 32] = model_out(r);
    accept();
    wait_done(n);
    snap = out_data;
    total++; if (snap !== want) begin bad++; $display("FAIL bp_result got=%h want=%h", snap, want); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = {$urandom(), $urandom(), $urandom()};
      if (i == 2) begin wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h0007_0000; end
      step();
      wr_en = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid%0d got=%b want=1", i, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%b want=0", i, in_ready); end
      total++; if (out_data !== want) begin bad++; $display("FAIL bp_stable%0d got=%h want=%h", i, out_data, want); end
    end
    in_valid = 1'b0;
    release_out();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== want) begin bad++; $display("FAIL bp_hold_after got=%h want=%h", out_data, want); end
    // The write issued in DONE must not have landed.
    for (int c = 0; c < IN_LEN; c++) cur_x[c] = $urandom_range(0, 32'h7_FFFF) - 32'h4_0000;
    for (int r = 0; r < OUT_LEN; r++) want[r*32 +: 32] = model_out(r);
    accept();
    wait_done(n);
    total++; if (out_data !== want) begin bad++; $display("FAIL done_write_drop got=%h want=%h", out_data, want); end
    release_out();
  endtask

  task automatic test_write_drop();
    int n;
    logic [95:0] want;
    tb_w[0][0] = 32'h0001_0000;
    wr(0, tb_w[0][0]);
    // Out-of-range addresses in IDLE are dropped as well.
    for (int a = 12; a < 16; a++) wr(a, $urandom());
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < IN_LEN; c++) cur_x[c] = $urandom_range(0, 32'h7_FFFF) - 32'h4_0000;
      for (int r = 0; r < OUT_LEN; r++) want[r*32 +: 32] = model_out(r);
      accept();
      if (k == 0) begin
        step();
        wr(0, 32'h0005_0000);
      end
      wait_done(n);
      total++; if (out_data !== want) begin bad++; $display("FAIL write_drop%0d got=%h want=%h", k, out_data, want); end
      release_out();
    end
  endtask

  task automatic test_same_edge();
    int n;
    logic [31:0] want0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < IN_LEN; c++) cur_x[c] = $urandom_range(0, 32'h7_FFFF) - 32'h4_0000;
      wr_en = 1'b1;
      wr_data = $urandom_range(0, 32'h7_FFFF) - 32'h4_0000;
      if (k == 0) begin wr_addr = 4'd3; tb_b[0] = wr_data; end
      else begin wr_addr = 4'd0; tb_w[0][0] = wr_data; end
      want0 = model_out(0);
      accept();
      wr_en = 1'b0;
      wait_done(n);
      total++; if (out_data[31:0] !== want0) begin bad++; $display("FAIL same_edge%0d got=%h want=%h", k, out_data[31:0], want0); end
      release_out();
    end
  endtask

  task automatic test_random();
    int n;
    logic [95:0] want;
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < OUT_LEN; r++) begin
        tb_b[r] = (k < 2) ? $urandom() : $urandom_range(0, 32'hF_FFFF) - 32'h8_0000;
        for (int c = 0; c < IN_LEN; c++)
          tb_w[r][c] = (k < 2) ? $urandom() : $urandom_range(0, 32'hF_FFFF) - 32'h8_0000;
      end
      load_model();
      for (int c = 0; c < IN_LEN; c++)
        cur_x[c] = (k < 2) ? $urandom() : $urandom_range(0, 32'hF_FFFF) - 32'h8_0000;
      for (int r = 0; r < OUT_LEN; r++) want[r*32 +: 32] = model_out(r);
      accept();
      wait_done(n);
      total++; if (n != 9) begin bad++; $display("FAIL random_latency%0d got=%0d want=9", k, n); end
      total++; if (out_data !== want) begin bad++; $display("FAIL random_out%0d got=%h want=%h", k, out_data, want); end
      release_out();
    end
  endtask

  task automatic test_reset_mid_compute();
    int n;
    for (int r = 0; r < OUT_LEN; r++) begin
      tb_b[r] = 32'h0001_0000;
      for (int c = 0; c < IN_LEN; c++) tb_w[r][c] = 32'h0002_0000;
    end
    load_model();
    for (int c = 0; c < IN_LEN; c++) cur_x[c] = 32'h0001_0000;
    accept();
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    #2 rst_n = 1'b1;
    clear_model();
    accept();
    wait_done(n);
    total++; if (n != 9) begin bad++; $display("FAIL midrst_latency got=%0d want=9", n); end
    total++; if (out_data !== 96'd0) begin bad++; $display("FAIL midrst_out got=%h want=0", out_data); end
    release_out();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_bias_negative();
    test_overflow();
    test_backpressure();
    test_write_drop();
    test_same_edge();
    test_random();
    test_reset_mid_compute();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dense_layer_mac.md
DENSE_LAYER_MAC -- requirements
Module: dense_layer_mac

Interface
REQ-001 Parameter IN_LEN, default 3, input vector length; must be at least 1.
REQ-002 Parameter OUT_LEN, default 3, output vector length, equal to downstream activation VECTOR_LEN; must be at least 1.
REQ-003 Parameter FRAC_BITS, default 16, fractional bits of the signed fixed-point format.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 wr_en  in  1  parameter write strobe.
REQ-007 wr_addr  in  $clog2(OUT_LEN*(IN_LEN+1))  parameter index; row*(IN_LEN+1)+col, where col=IN_LEN selects the row's bias.
REQ-008 wr_data  in  32  signed weight or bias value.
REQ-009 in_valid  in  1  in_data holds a valid input vector.
REQ-010 in_ready  out  1  block can accept a vector.
REQ-011 in_data  in  signed 32 x IN_LEN  input vector.
REQ-012 out_valid  out  1  out_data holds a valid result vector.
REQ-013 out_ready  in  1  downstream accepts out_data.
REQ-014 out_data  out  signed 32 x OUT_LEN  result vector; feeds the activation stage's data_in.

Function
REQ-015 Computes out[r] = (b[r]<<FRAC_BITS + sum over c of w[r][c]*x[c]) >>> FRAC_BITS: one 32x32 to 64 signed MAC per cycle, row-major.
REQ-016 FSM states: IDLE, COMPUTE, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 IDLE -> COMPUTE on an edge with in_valid=1: capture in_data, set row=0 and col=0, acc = sign-extended b[0]<<FRAC_BITS.
REQ-018 COMPUTE: each edge acc += w[row][col]*x[col]; at col=IN_LEN-1 write the converted acc to out_data[row], reload acc with the next row's bias, set col=0, and row+1.
REQ-019 The final MAC edge (row=OUT_LEN-1, col=IN_LEN-1) moves the FSM to DONE; out_valid therefore rises exactly OUT_LEN*IN_LEN edges after the accepting edge.
REQ-020 DONE -> IDLE on an edge with out_ready=1; out_data holds stable while out_valid=1 and out_ready=0, and keeps its last value after the transfer.
REQ-021 The accumulator is 64-bit signed and wraps modulo 2^64; >>> is an arithmetic shift (floor rounding).
REQ-022 32-bit conversion of the shifted accumulator follows REQ-028/REQ-029.
REQ-023 Parameter writes take effect only in IDLE; writes in COMPUTE or DONE, and writes with out-of-range wr_addr, are dropped.
REQ-024 wr_en and the in_valid capture on the same IDLE edge: the write lands, and the computation uses the new value.
REQ-025 The weight/bias memory persists across vectors; no re-load is required between vectors.

Reset
REQ-026 rst_n=0, at any time including mid-COMPUTE, immediately forces: state=IDLE, in_ready=1, out_valid=0, out_data=0, acc=0, row=col=0, all weights and biases=0.
REQ-027 The first acceptance after reset release can occur on the first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-028 Macro DENSE_LAYER_MAC_SATURATE_EN defined: the shifted accumulator clamps to [0x80000000, 0x7FFFFFFF] when it is outside the signed 32-bit range.
REQ-029 Macro DENSE_LAYER_MAC_SATURATE_EN undefined: conversion takes the low 32 bits (wrap); no clamping logic is synthesised.

Verification (IN_LEN=OUT_LEN=3, FRAC_BITS=16)
REQ-030 Identity test: w = 0x00010000 on the diagonal, all other weights 0, biases 0, x = {0x10000, 0x20000, 0xFFFF0000}.
- Required output: out = {0x10000, 0x20000, 0xFFFF0000}.
- out_valid rises exactly 9 edges after the accepting edge.
REQ-031 Bias and negative test: all weights 0x00008000 (0.5), b = {0x10000, 0, 0xFFFE0000}, x = {0x20000, 0x20000, 0xFFFE0000}.
- Required output: out = {0x20000, 0x10000, 0xFFFF0000}.
REQ-032 Overflow test: w[0][0] = 0x7FFF0000, all other parameters 0, x[0] = 0x7FFF0000.
- With the macro defined: out[0] = 0x7FFFFFFF.
- With the macro undefined: out[0] = 0x00010000.
REQ-033 Backpressure test: hold out_ready=0 for 5 cycles in DONE.
- out_data is stable, in_ready=0, and in_valid is ignored.
- Raising out_ready returns the FSM to IDLE one edge later.
REQ-034 Write-drop test: issue wr_en with addr 0 and data 0x50000 during COMPUTE.
- The current result is unchanged, and the next vector still uses the old w[0][0].
REQ-035 Reset-mid-compute test: assert rst_n=0 at col=1 of row 1.
- out_valid=0 and in_ready=1 immediately.
- The next vector with x = {0x10000, 0x10000, 0x10000} yields out = {0, 0, 0}.
